matmult_kernel_param: RTL

- Parametrised successor to the fixed 16x16 dot-product kernel: computes C = A x B for square signed NxN matrices.
- LANES multipliers feed a pipelined binary adder tree; a final accumulator stage sums N/LANES partial dot products per output element.
- Sits between the A/B input buffers (row of A, column of B fetched LANES elements per read) and the C output buffer.
- Adds a Busy/Done handshake and a synchronous reset.

---
 rtl/matmult_kernel_param.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/matmult_kernel_param.sv
// Parametrised signed NxN matrix multiply kernel, C = A x B.
// Ports: Clk/Rst (sync, active high); Start/Busy/Done job handshake;
//   Rd_en/Rd_A_addr/Rd_B_addr/Rd_chunk drive the A/B buffers, whose
//   A_vec/B_vec return LANES elements one cycle later;
//   Wr_en/Wr_addr/C write one result element to the C buffer.
module matmult_kernel_param #(
    parameter int DW = 8,
    parameter int N = 16,
    parameter int LANES = 16,
    parameter int AW = $clog2(N),
    parameter int OW = 2 * DW + $clog2(N),
    localparam int TL = $clog2(LANES),
    localparam int P = N / LANES,
    localparam int CW = (P > 1) ? $clog2(P) : 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Done,
    input  logic [LANES*DW-1:0]  A_vec,
    input  logic [LANES*DW-1:0]  B_vec,
    output logic                 Rd_en,
    output logic [AW-1:0]        Rd_A_addr,
    output logic [AW-1:0]        Rd_B_addr,
    output logic [CW-1:0]        Rd_chunk,
    output logic                 Wr_en,
    output logic [2*AW-1:0]      Wr_addr,
    output logic signed [OW-1:0] C
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    // Sideband word: {valid, first, last, i, j}
    localparam int SBW = 3 + 2 * AW;

    state_t state;

    logic [SBW-1:0] sb [TL+2];
    logic [SBW-1:0] sb_in;

    logic signed [DW-1:0]   a_l  [LANES];
    logic signed [DW-1:0]   b_l  [LANES];
    logic signed [2*DW-1:0] prod [LANES];

    // Heap-ordered adder tree: node n sums nodes 2n+1 and 2n+2,
    // leaves (products) live at LANES-1+k, root at 0.
    logic signed [OW-1:0] node [2*LANES-1];

    logic signed [OW-1:0] acc;
    logic signed [OW-1:0] acc_next;

    logic p_last, j_last, i_last;
    logic sb_v, sb_f, sb_l;
    logic [2*AW-1:0] sb_a;

    assign p_last = (Rd_chunk == CW'(P - 1));
    assign j_last = (Rd_B_addr == AW'(N - 1));
    assign i_last = (Rd_A_addr == AW'(N - 1));

    assign sb_in = {Rd_en, (Rd_chunk == '0), p_last,
                    Rd_A_addr, Rd_B_addr};

    assign sb_v = sb[TL+1][SBW-1];
    assign sb_f = sb[TL+1][SBW-2];
    assign sb_l = sb[TL+1][SBW-3];
    assign sb_a = sb[TL+1][2*AW-1:0];

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            a_l[k]  = $signed(A_vec[k*DW +: DW]);
            b_l[k]  = $signed(B_vec[k*DW +: DW]);
            prod[k] = (2*DW)'(a_l[k]) * (2*DW)'(b_l[k]);
        end
    end

    assign acc_next = sb_f ? node[0] : acc + node[0];

    // Sideband delay: sb[0] aligns with memory data, sb[1] with the
    // products, sb[TL+1] with the tree root.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int s = 0; s < TL + 2; s++)
                sb[s] <= '0;
        end else begin
            sb[0] <= sb_in;
            for (int s = 1; s < TL + 2; s++)
                sb[s] <= sb[s-1];
        end
    end

    always_ff @(posedge Clk) begin
        for (int k = 0; k < LANES; k++)
            node[LANES-1+k] <= OW'(prod[k]);
        for (int n = 0; n < LANES - 1; n++)
            node[n] <= node[2*n+1] + node[2*n+2];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc     <= '0;
            Wr_en   <= 1'b0;
            Wr_addr <= '0;
            C       <= '0;
        end else begin
            Wr_en <= 1'b0;
            if (sb_v) begin
                acc <= acc_next;
                if (sb_l) begin
                    Wr_en   <= 1'b1;
                    Wr_addr <= sb_a;
                    C       <= acc_next;
                end
            end
        end
    end

    // Rd_en is low on the first READ cycle, so reads begin one cycle
    // after the accepting edge.  Busy is held through the Done cycle
    // and cleared in IDLE while Done is still high.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Rd_en     <= 1'b0;
            Rd_A_addr <= '0;
            Rd_B_addr <= '0;
            Rd_chunk  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Done) begin
                        Busy <= 1'b0;
                    end else if (Start) begin
                        state     <= READ;
                        Busy      <= 1'b1;
                        Rd_A_addr <= '0;
                        Rd_B_addr <= '0;
                        Rd_chunk  <= '0;
                    end
                end
                READ: begin
                    if (!Rd_en) begin
                        Rd_en <= 1'b1;
                    end else if (p_last && j_last && i_last) begin
                        Rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        Rd_chunk <= p_last ? '0 : Rd_chunk + CW'(1);
                        if (p_last) begin
                            Rd_B_addr <= j_last ? '0
                                                : Rd_B_addr + AW'(1);
                            if (j_last)
                                Rd_A_addr <= Rd_A_addr + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (Wr_en && Wr_addr == (2*AW)'(N * N - 1)) begin
                        Done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
